// File: rtl/mac_loopback_pkt_gen.sv
// mac_loopback_pkt_gen: patterned packet generator driving the MAC TX stream,
// plus a checker for the looped-back RX stream with counters and a pass/fail verdict.
module mac_loopback_pkt_gen #(
  parameter int unsigned PKT_BEATS   = 8,
  parameter int unsigned NUM_PKTS    = 16,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        mac_ready,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [15:0] tx_pkt_cnt,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] err_cnt,
  output logic        done,
  output logic        pass
);

  localparam int unsigned CW = 16;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(PKT_BEATS - 1);
  localparam logic [CW-1:0] NUM_PKTS_C = CW'(NUM_PKTS);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT);

  typedef enum logic [1:0] {WAIT_READY, SEND, GAP, TX_DONE} tx_state_e;

  function automatic logic [63:0] pattern(input logic [CW-1:0] p, input logic [CW-1:0] b);
    return {16'hC0DE, p, b, 16'h5A5A};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // TX side registers
  tx_state_e     state_q, state_d;
  logic [63:0]   tdata_q, tdata_d;
  logic [7:0]    tkeep_q, tkeep_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;

  // RX checker registers
  logic [CW-1:0] ep_q, ep_d;
  logic [CW-1:0] eb_q, eb_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          pkt_err_q, pkt_err_d;
  logic [TW-1:0] to_q, to_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          tx_hs_c;
  logic          tx_last_hs_c;
  logic [CW-1:0] tx_cnt_inc_c;
  logic [CW-1:0] beat_inc_c;
  logic          rx_mism_c;
  logic          rx_bad_c;

  assign tx_hs_c      = tvalid_q & tx_axis_tready;
  assign tx_last_hs_c = tx_hs_c & tlast_q;
  assign tx_cnt_inc_c = sat_inc(tx_cnt_q);
  assign beat_inc_c   = beat_q + CW'(1);

  // A beat is bad if its contents, keep or tlast position disagree with the expected packet
  assign rx_mism_c = (rx_axis_tdata != pattern(ep_q, eb_q)) |
                     (rx_axis_tkeep != 8'hFF) |
                     (rx_axis_tlast != (eb_q == LAST_BEAT)) |
                     (eb_q > LAST_BEAT);
  assign rx_bad_c  = rx_mism_c | (rx_axis_tlast & rx_axis_tuser);

  // TX state register
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) state_q <= WAIT_READY;
    else           state_q <= state_d;
  end

  // TX next-state: mac_ready is only consulted before a packet starts, never mid-packet
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_READY: if (mac_ready) state_d = SEND;
      SEND:       if (tx_last_hs_c) state_d = (tx_cnt_inc_c == NUM_PKTS_C) ? TX_DONE : GAP;
      GAP:        if (gap_q == GAP_LAST) state_d = mac_ready ? SEND : WAIT_READY;
      TX_DONE:    state_d = TX_DONE;
      default:    state_d = WAIT_READY;
    endcase
  end

  // TX outputs: load the first beat on packet start, advance only on handshake
  always_comb begin
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    tx_cnt_d = tx_cnt_q;
    case (state_q)
      WAIT_READY, GAP: begin
        if (state_q == GAP) gap_d = gap_q + CW'(1);
        if (state_d == SEND) begin
          tvalid_d = 1'b1;
          tkeep_d  = 8'hFF;
          beat_d   = '0;
          tdata_d  = pattern(tx_cnt_q, '0);
          tlast_d  = 1'b0;
        end
      end
      SEND: begin
        if (tx_hs_c) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tx_cnt_d = tx_cnt_inc_c;
            gap_d    = '0;
          end else begin
            beat_d  = beat_inc_c;
            tdata_d = pattern(tx_cnt_q, beat_inc_c);
            tlast_d = (beat_inc_c == LAST_BEAT);
          end
        end
      end
      default: ;
    endcase
  end

  // RX checker, timeout and verdict next-state
  always_comb begin
    ep_d      = ep_q;
    eb_d      = eb_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    pkt_err_d = pkt_err_q;
    to_d      = to_q;
    done_d    = done_q;
    pass_d    = pass_q;
    if (rx_axis_tvalid) begin
      if (rx_bad_c && !pkt_err_q) err_cnt_d = sat_inc(err_cnt_q);
      if (rx_axis_tlast) begin
        rx_cnt_d  = sat_inc(rx_cnt_q);
        ep_d      = sat_inc(ep_q);
        eb_d      = '0;
        pkt_err_d = 1'b0;
      end else begin
        eb_d      = sat_inc(eb_q);
        pkt_err_d = pkt_err_q | rx_bad_c;
      end
    end
    if (rx_axis_tvalid) begin
      to_d = '0;
    end else if ((state_q == TX_DONE) && (to_q != TIMEOUT_C)) begin
      to_d = to_q + TW'(1);
    end
    if (!done_q && ((rx_cnt_q >= NUM_PKTS_C) || (to_q == TIMEOUT_C))) begin
      done_d = 1'b1;
      pass_d = (err_cnt_q == '0) && (rx_cnt_q == NUM_PKTS_C);
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      beat_q    <= '0;
      gap_q     <= '0;
      tx_cnt_q  <= '0;
      ep_q      <= '0;
      eb_q      <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      pkt_err_q <= 1'b0;
      to_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      tx_cnt_q  <= tx_cnt_d;
      ep_q      <= ep_d;
      eb_q      <= eb_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      pkt_err_q <= pkt_err_d;
      to_q      <= to_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign tx_axis_tdata  = tdata_q;
  assign tx_axis_tkeep  = tkeep_q;
  assign tx_axis_tvalid = tvalid_q;
  assign tx_axis_tlast  = tlast_q;
  assign tx_pkt_cnt     = tx_cnt_q;
  assign rx_pkt_cnt     = rx_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign done           = done_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_mac_loopback_pkt_gen.sv
// Bench for mac_loopback_pkt_gen: a behavioural loopback path with fault injection,
// a beat-sequence scoreboard on TX and a packet-level model of the expected RX counters.
`timescale 1ns/1ps
module tb_mac_loopback_pkt_gen;

  localparam int PB   = 8;
  localparam int NP   = 16;
  localparam int IDLE = 4;
  localparam int TO   = 200;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic        mac_ready;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tvalid;
  logic        tx_axis_tlast;
  logic        tx_axis_tready;
  logic [63:0] rx_axis_tdata;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tvalid;
  logic        rx_axis_tlast;
  logic        rx_axis_tuser;
  logic [15:0] tx_pkt_cnt;
  logic [15:0] rx_pkt_cnt;
  logic [15:0] err_cnt;
  logic        done;
  logic        pass;

  mac_loopback_pkt_gen #(
    .PKT_BEATS(PB), .NUM_PKTS(NP), .IDLE_CYCLES(IDLE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .sys_reset(sys_reset), .mac_ready(mac_ready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .err_cnt(err_cnt),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit rand_ready = 1'b0;
  bit corrupt_en = 1'b0;
  bit drop_en    = 1'b0;
  bit break_en   = 1'b0;

  int acc_cnt = 0;
  int cyc = 0;
  int start_cyc[NP];
  int m_rx = 0;
  int m_err = 0;
  logic [72:0] cur_q[$];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int p, input int b);
    logic [15:0] pp;
    logic [15:0] bb;
    pp = 16'(p);
    bb = 16'(b);
    return {16'hC0DE, pp, bb, 16'h5A5A};
  endfunction

  // Packet-level model: a received packet is clean only if it is exactly the expected packet
  task automatic model_beat(input logic [72:0] beat);
    bit bad;
    cur_q.push_back(beat);
    if (beat[0]) begin
      bad = (cur_q.size() != PB);
      foreach (cur_q[i])
        if (cur_q[i] !== {pat(m_rx, i), 8'hFF, (i == PB - 1)}) bad = 1'b1;
      m_rx++;
      m_err += int'(bad);
      cur_q.delete();
    end
  endtask

  // Loopback path: backpressure, TX scoreboard, stall-stability check, fault injection
  initial begin
    int p;
    int b;
    logic [63:0] d;
    logic l;
    bit fwd;
    bit stall_prev;
    logic [72:0] hold;
    stall_prev = 1'b0;
    hold = '0;
    tx_axis_tready = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata = '0;
    rx_axis_tkeep = '0;
    rx_axis_tlast = 1'b0;
    rx_axis_tuser = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_prev && !sys_reset)
        check("tx_hold", 80'({tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}),
              80'({1'b1, hold}));
      tx_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tdata  = '0;
      rx_axis_tkeep  = '0;
      if (sys_reset) begin
        acc_cnt = 0;
        m_rx = 0;
        m_err = 0;
        cur_q.delete();
      end else if (tx_axis_tvalid && tx_axis_tready) begin
        p = acc_cnt / PB;
        b = acc_cnt % PB;
        check("tx_beat", 80'({tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}),
              80'({pat(p, b), 8'hFF, (b == PB - 1)}));
        if (b == 0 && p < NP) start_cyc[p] = cyc;
        acc_cnt++;
        fwd = !(break_en && p >= 10) && !(drop_en && p == 2 && b == PB - 1);
        d = tx_axis_tdata;
        l = tx_axis_tlast;
        if (corrupt_en && p == 5 && b == 3) d[0] = ~d[0];
        if (drop_en && p == 2 && b == PB - 2) l = 1'b1;
        if (fwd) begin
          rx_axis_tvalid = 1'b1;
          rx_axis_tdata  = d;
          rx_axis_tkeep  = 8'hFF;
          rx_axis_tlast  = l;
          model_beat({d, 8'hFF, l});
        end
      end
      stall_prev = !sys_reset && tx_axis_tvalid && !tx_axis_tready;
      hold = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast};
    end
  end

  task automatic do_reset();
    #1;
    sys_reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    sys_reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check(tag, 80'(done), 80'(1));
  endtask

  task automatic final_checks(input string tag, input int exp_rx, input int exp_err, input bit exp_pass);
    check({tag, "_tx"}, 80'(tx_pkt_cnt), 80'(NP));
    check({tag, "_rx"}, 80'(rx_pkt_cnt), 80'(exp_rx));
    check({tag, "_rx_model"}, 80'(rx_pkt_cnt), 80'(m_rx));
    check({tag, "_err"}, 80'(err_cnt), 80'(exp_err));
    check({tag, "_err_model"}, 80'(err_cnt), 80'(m_err));
    check({tag, "_done"}, 80'(done), 80'(1));
    check({tag, "_pass"}, 80'(pass), 80'(exp_pass));
  endtask

  initial begin
    bit hit;
    sys_reset = 1'b1;
    mac_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 80'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata, tx_axis_tkeep}), 80'(0));
    check("rst_cnt", 80'({tx_pkt_cnt, rx_pkt_cnt, err_cnt, done, pass}), 80'(0));
    #1;
    sys_reset = 1'b0;

    // Clean loopback with tready held high, including start latency and gap spacing
    repeat (5) @(negedge clk);
    check("idle_no_valid", 80'(tx_axis_tvalid), 80'(0));
    #1;
    mac_ready = 1'b1;
    @(negedge clk);
    check("valid_rise", 80'(tx_axis_tvalid), 80'(1));
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (rx_pkt_cnt == 16'(NP)) hit = 1'b1;
    end
    check("clean_rx_reached", 80'(rx_pkt_cnt), 80'(NP));
    check("clean_done_lag", 80'(done), 80'(0));
    @(negedge clk);
    final_checks("clean", NP, 0, 1'b1);
    check("pkt_spacing", 80'(start_cyc[1] - start_cyc[0]), 80'(PB + IDLE));
    check("run_spacing", 80'(start_cyc[NP-1] - start_cyc[0]), 80'((NP - 1) * (PB + IDLE)));

    // Random backpressure
    rand_ready = 1'b1;
    do_reset();
    wait_done("bp_wait", 3000);
    final_checks("bp", NP, 0, 1'b1);
    rand_ready = 1'b0;

    // Single bit flip in packet 5 beat 3
    corrupt_en = 1'b1;
    do_reset();
    wait_done("corrupt_wait", 1000);
    @(negedge clk);
    final_checks("corrupt", NP, 1, 1'b0);
    corrupt_en = 1'b0;

    // Packet 2 truncated to 7 beats with early tlast
    drop_en = 1'b1;
    do_reset();
    wait_done("drop_wait", 1000);
    @(negedge clk);
    final_checks("drop", NP, 1, 1'b0);
    drop_en = 1'b0;

    // Loopback broken after packet 10: verdict from the timeout
    break_en = 1'b1;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (tx_pkt_cnt == 16'(NP)) hit = 1'b1;
    end
    check("brk_tx_reached", 80'(tx_pkt_cnt), 80'(NP));
    repeat (TO) @(negedge clk);
    check("brk_done_early", 80'(done), 80'(0));
    @(negedge clk);
    final_checks("brk", 10, 0, 1'b0);
    break_en = 1'b0;

    // mac_ready drop during packet 4 beat 2, resume, then reset mid-packet
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= 4 * PB + 3) hit = 1'b1;
    end
    check("mr_reach_p4", 80'(hit), 80'(1));
    mac_ready = 1'b0;
    repeat (40) @(negedge clk);
    check("mr_stall_cnt", 80'(tx_pkt_cnt), 80'(5));
    check("mr_stall_valid", 80'(tx_axis_tvalid), 80'(0));
    #1;
    check("mr_stall_beats", 80'(acc_cnt), 80'(5 * PB));
    mac_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= 5 * PB + 4) hit = 1'b1;
    end
    check("mr_resume", 80'(hit), 80'(1));
    check("mr_mid_valid", 80'(tx_axis_tvalid), 80'(1));
    sys_reset = 1'b1;
    #1;
    check("mid_rst_tx", 80'({tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata, tx_axis_tkeep}), 80'(0));
    check("mid_rst_cnt", 80'({tx_pkt_cnt, rx_pkt_cnt, err_cnt, done, pass}), 80'(0));
    repeat (2) @(negedge clk);
    #1;
    sys_reset = 1'b0;
    wait_done("restart_wait", 1000);
    @(negedge clk);
    final_checks("restart", NP, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_loopback_pkt_gen.md
# mac_loopback_pkt_gen

Self-checking traffic generator and checker for the QSFP 25GE MAC datapath, instantiated beside the MAC inside the QSFP top. Once the MAC reports `mac_ready`, it drives a fixed count of patterned packets into the MAC TX AXI-Stream port. It receives the looped-back frames on the MAC RX AXI-Stream port, checks every beat against the expected pattern, and reports packet/error counters plus a done/pass verdict. This lets the board and the simulation bench confirm link health without external traffic.

## Interface
Parameters:
- `PKT_BEATS`, 8: beats per packet; ≥8, so frames are ≥64 bytes; ≤65535.
- `NUM_PKTS`, 16: packets per run; 1..65535.
- `IDLE_CYCLES`, 4: gap cycles between packets; ≥1.
- `TIMEOUT`, 4096: RX-silent cycles after the last TX before failing the run.

Ports:
- `clk` in 1: MAC user-side clock; only clock.
- `sys_reset` in 1: asynchronous, active-high reset.
- `mac_ready` in 1: MAC link ready; synchronous to `clk`.
- `tx_axis_tdata` out 64, `tx_axis_tkeep` out 8, `tx_axis_tvalid` out 1, `tx_axis_tlast` out 1: TX stream to the MAC.
- `tx_axis_tready` in 1: MAC TX backpressure.
- `rx_axis_tdata` in 64, `rx_axis_tkeep` in 8, `rx_axis_tvalid` in 1, `rx_axis_tlast` in 1: RX stream from the MAC; no backpressure.
- `rx_axis_tuser` in 1: frame error; valid on the `tlast` beat.
- `tx_pkt_cnt` out 16, `rx_pkt_cnt` out 16, `err_cnt` out 16: run counters.
- `done` out 1, `pass` out 1: run verdict.

## Operation
- Beat pattern, for packet p and beat b: `tdata = {16'hC0DE, p[15:0], b[15:0], 16'h5A5A}`.
  - `tkeep` is 8'hFF on every beat.
  - `tlast` is high when b = PKT_BEATS-1.
- TX FSM states: WAIT_READY, SEND, GAP, TX_DONE.
  - WAIT_READY: if `mac_ready`=1, go to SEND.
  - SEND: on the handshake (`tvalid & tready`) of the `tlast` beat, increment `tx_pkt_cnt`.
    - Go to TX_DONE if `tx_pkt_cnt` then equals NUM_PKTS.
    - Otherwise go to GAP.
  - GAP: count IDLE_CYCLES cycles with `tvalid`=0.
    - At the end, go to SEND if `mac_ready`=1, else to WAIT_READY.
  - TX_DONE: terminal until reset.
- `mac_ready` falling mid-packet: the current packet completes. `tvalid` is never retracted before its handshake; the check happens only at the next GAP exit.
- AXI rule: while `tvalid`=1 and `tready`=0, `tdata`/`tkeep`/`tlast` hold stable.
- RX checker keeps an expected packet index `ep` and beat index `eb`, both starting at 0. On each `rx_axis_tvalid` beat:
  - Mismatch: any of `tdata` ≠ pattern(ep, eb), `tkeep` ≠ FF, or `tlast` ≠ (eb = PKT_BEATS-1). Mismatch increments `err_cnt` at most once per packet.
  - `tlast`=1 with `tuser`=1: increments `err_cnt`. If the packet already has a mismatch, it is still counted only once.
  - `tlast`=1 (any position): `rx_pkt_cnt`++, `ep`++, `eb` ← 0. An early or late `tlast` therefore resynchronises to the next packet.
  - Otherwise: `eb`++.
  - If `eb` reaches PKT_BEATS without `tlast`: flag a mismatch and keep counting. `eb` saturates at 16'hFFFF.
- All counters saturate at 16'hFFFF.
- Completion:
  - `done` ← 1 when `rx_pkt_cnt` reaches NUM_PKTS, or when in TX_DONE with TIMEOUT consecutive cycles of `rx_axis_tvalid`=0.
  - `pass` = `done` & (`err_cnt`=0) & (`rx_pkt_cnt`=NUM_PKTS). It is registered and updated together with `done`.
  - Once set, `done`/`pass` hold until reset. RX beats after `done` still update the counters, but the verdict does not change.

## Timing
- Reset values: `tx_axis_tvalid`=0, `tlast`=0, `tdata`=0, `tkeep`=0; all counters 0; `done`=0; `pass`=0; FSM in WAIT_READY; `ep`=`eb`=0.
- Assertion of `sys_reset` at any time (including mid-packet) clears everything immediately. TX restarts at packet 0 after release.
- All outputs are registered.
- `tx_axis_tvalid` rises on the edge that samples `mac_ready`=1 in WAIT_READY, or the edge that ends GAP.
- With `tready` held high, beats issue back-to-back. A packet occupies PKT_BEATS cycles, followed by IDLE_CYCLES gap cycles.
- Counters update on the edge of the qualifying handshake or beat, and are visible in the next cycle.
- `done`/`pass` rise one edge after the qualifying `rx_pkt_cnt` update or timeout expiry.
- TIMEOUT counter: clears on any RX beat; counts only in TX_DONE.

## Test plan
- Loopback, `tready`=1, defaults: `mac_ready` rises → 16 packets of 8 beats, 4-cycle gaps. Expect `tx_pkt_cnt`=`rx_pkt_cnt`=16, `err_cnt`=0, `done`=`pass`=1.
- Random `tready` backpressure, ~50% duty: TX data is stable while stalled, no beat is lost or duplicated, and the run still ends with `pass`=1.
- Corrupt beat 3 of packet 5 (flip bit 0) in the loopback path → `err_cnt`=1, `rx_pkt_cnt`=16, `done`=1, `pass`=0.
- Drop the `tlast` beat of packet 2, i.e. it arrives as 7 beats with `tlast` on beat 6 → `err_cnt`=1, later packets check clean, `rx_pkt_cnt`=16, `pass`=0.
- Break the loopback after packet 10 → timeout fires TIMEOUT cycles after TX_DONE: `done`=1, `pass`=0, `rx_pkt_cnt`=10.
- Deassert `mac_ready` during packet 4 beat 2: packet 4 completes and TX stalls in WAIT_READY. Re-assert → packet 5 starts. Assert `sys_reset` mid-packet → all outputs return to reset values.
